regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the processor register file and shares it between three requesters: load-immediate (always writes r3), ALU writeback, and returning memory loads.
- Memory loads are buffered in a small load queue (LQ).
- A per-register scoreboard marks registers with outstanding loads. Decode uses it to stall on RAW and WAW hazards.
- Sits between decode/ALU/data memory and the register file's WriteEn/Waddr/DataIn inputs.

Parameters:
W, 8, data path width
A, 4, register address width (2**A registers)
LQ_DEPTH, 2, load-queue entries (power of 2, >=2)
MAX_WAIT, 3, cycles a non-empty LQ head may lose arbitration before it is forced (aging only)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
imm_valid  in  1  load-immediate request
imm_data  in  W  immediate value (destination fixed to r3)
imm_ready  out  1  immediate granted this cycle
alu_valid  in  1  ALU writeback request
alu_addr  in  A  ALU destination register
alu_data  in  W  ALU result
alu_ready  out  1  ALU writeback granted this cycle
ld_issue  in  1  decode sent a load to memory
ld_addr  in  A  destination register of issued load
ld_ret_valid  in  1  memory load data available
ld_ret_addr  in  A  destination register of returned load
ld_ret_data  in  W  returned load data
ld_ret_ready  out  1  LQ accepts return (= LQ not full)
src_a_addr  in  A  decode source register A
src_b_addr  in  A  decode source register B
stall  out  1  decode hazard stall
busy_vec  out  2**A  scoreboard, bit i = load outstanding to ri
WriteEn  out  1  register file write enable (registered)
Waddr  out  A  register file write address (registered)
DataIn  out  W  register file write data (registered)

Behaviour:
- Handshake: a transfer occurs when valid && ready on the same edge. A requester holds valid and its payload stable until it sees ready. Ready is combinational from the valids, the scoreboard and the LQ state.
- Arbitration, one grant per cycle. Default priority is IMM > ALU > LQ head.
- IMM is eligible only if busy_vec[3]==0.
- ALU is eligible only if busy_vec[alu_addr]==0 (WAW protection).
- LQ is eligible only if not empty.
- Latency: grant at edge N drives WriteEn=1 plus the winner's Waddr/DataIn from edge N to N+1. With no grant, WriteEn=0 and Waddr/DataIn hold their last values.
- LQ: ld_ret_valid && ld_ret_ready enqueues {addr,data} at the edge. It is FIFO order with wrap-around pointers. An entry enqueued at edge N is eligible from cycle N+1, so the earliest write is at edge N+2.
- LQ full: ld_ret_ready=0 until a dequeue edge. Enqueue and dequeue on the same edge with the LQ not full are both performed; occupancy is unchanged.
- Scoreboard:
  - ld_issue sets busy_vec[ld_addr] at the edge.
  - An LQ-head grant clears busy_vec[head addr] at the edge.
  - A set and a clear of the same address on the same edge: the set wins.
- stall = busy_vec[src_a_addr] | busy_vec[src_b_addr] | (ld_issue & busy_vec[ld_addr]). Decode must not assert ld_issue when busy_vec[ld_addr] is set; this is guaranteed by decode honouring stall.
- Reset:
  - WriteEn=0, Waddr=0, DataIn=0.
  - LQ emptied; ld_ret_ready=1 in the following cycle.
  - busy_vec=0, age counter=0, stall=0.
  - Reset mid-operation discards queued loads and clears all busy bits; no write is issued during or in the cycle after reset.
- Width: pointers are log2(LQ_DEPTH) bits with a separate count of log2(LQ_DEPTH)+1 bits. The age counter saturates at MAX_WAIT.

Optional Feature:
- Macro REGFILE_WB_AGING_EN.
- Defined:
  - The age counter increments each cycle the LQ is non-empty and the head is not granted.
  - It clears on an LQ grant or when the LQ is empty.
  - When age==MAX_WAIT, the LQ head wins over IMM and ALU.
- Undefined: no age counter; fixed IMM > ALU > LQ priority. The LQ can starve under continuous ALU traffic, and ports are unchanged.

Test Plan:
- Reset, then imm_valid=1, imm_data=0x5A at edge 1 -> imm_ready=1 in cycle 1; WriteEn=1, Waddr=3, DataIn=0x5A after edge 1; WriteEn=0 after edge 2.
- imm_valid and alu_valid (r4, 0x11) in the same cycle -> IMM granted first, ALU granted the next cycle; writes r3 then r4 on consecutive cycles.
- ld_issue r5, then src_a_addr=5 -> stall=1. ld_ret r5 0x77 -> enqueued, write r5=0x77 two edges later, busy_vec[5]=0 and stall=0 after the write.
- Three ld_ret in consecutive cycles with alu_valid held high (LQ_DEPTH=2) -> ld_ret_ready=0 on the third; entries written in FIFO order; no entry lost.
- With REGFILE_WB_AGING_EN, alu_valid continuously high and LQ holding one entry -> LQ granted after exactly MAX_WAIT=3 lost cycles. Without the macro, the LQ is never granted while ALU is valid.
- Reset asserted with 2 LQ entries and busy_vec=0x0060 -> busy_vec=0, LQ empty, no WriteEn pulse for queued data.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: load-immediate (r3), ALU writeback and a load-return queue.
// Define REGFILE_WB_AGING_EN to let a starved LQ head win after MAX_WAIT lost cycles.
module regfile_wb_arbiter #(
    parameter int W        = 8,
    parameter int A        = 4,
    parameter int LQ_DEPTH = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              imm_valid,
    input  logic [W-1:0]      imm_data,
    output logic              imm_ready,
    input  logic              alu_valid,
    input  logic [A-1:0]      alu_addr,
    input  logic [W-1:0]      alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [A-1:0]      ld_addr,
    input  logic              ld_ret_valid,
    input  logic [A-1:0]      ld_ret_addr,
    input  logic [W-1:0]      ld_ret_data,
    output logic              ld_ret_ready,
    input  logic [A-1:0]      src_a_addr,
    input  logic [A-1:0]      src_b_addr,
    output logic              stall,
    output logic [2**A-1:0]   busy_vec,
    output logic              WriteEn,
    output logic [A-1:0]      Waddr,
    output logic [W-1:0]      DataIn
);
    localparam int NREG = 2**A;
    localparam int PW   = $clog2(LQ_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [A-1:0] IMM_REG = A'(3);

    logic [A-1:0]    lq_addr_q [LQ_DEPTH];
    logic [A-1:0]    lq_addr_d [LQ_DEPTH];
    logic [W-1:0]    lq_data_q [LQ_DEPTH];
    logic [W-1:0]    lq_data_d [LQ_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            we_q, we_d;
    logic [A-1:0]    waddr_q, waddr_d;
    logic [W-1:0]    wdata_q, wdata_d;

    logic lq_empty, lq_full;
    logic imm_elig, alu_elig, lq_elig, lq_force;
    logic gnt_imm, gnt_alu, gnt_lq, enq;

    assign lq_empty = (count_q == '0);
    assign lq_full  = (count_q == CW'(LQ_DEPTH));
    assign imm_elig = imm_valid && !busy_q[IMM_REG];
    assign alu_elig = alu_valid && !busy_q[alu_addr];
    assign lq_elig  = !lq_empty;

`ifdef REGFILE_WB_AGING_EN
    localparam int AW = $clog2(MAX_WAIT + 1);
    logic [AW-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (lq_empty || gnt_lq)
            age_d = '0;
        else if (age_q != AW'(MAX_WAIT))
            age_d = age_q + AW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            age_q <= '0;
        else
            age_q <= age_d;
    end

    assign lq_force = lq_elig && (age_q == AW'(MAX_WAIT));
`else
    assign lq_force = 1'b0;
`endif

    // Nothing is granted or accepted while Reset is high, so no transfer is lost to the reset.
    always_comb begin
        gnt_imm = 1'b0;
        gnt_alu = 1'b0;
        gnt_lq  = 1'b0;
        if (!Reset) begin
            if (lq_force)
                gnt_lq = 1'b1;
            else if (imm_elig)
                gnt_imm = 1'b1;
            else if (alu_elig)
                gnt_alu = 1'b1;
            else if (lq_elig)
                gnt_lq = 1'b1;
        end
    end

    assign imm_ready    = gnt_imm;
    assign alu_ready    = gnt_alu;
    assign ld_ret_ready = !lq_full && !Reset;
    assign enq          = ld_ret_valid && ld_ret_ready;

    always_comb begin
        lq_addr_d = lq_addr_q;
        lq_data_d = lq_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (enq) begin
            lq_addr_d[tail_q] = ld_ret_addr;
            lq_data_d[tail_q] = ld_ret_data;
            tail_d            = tail_q + PW'(1);
        end
        if (gnt_lq)
            head_d = head_q + PW'(1);
        case ({enq, gnt_lq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // The set is applied after the clear so a same-address issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (gnt_lq)
            busy_d[lq_addr_q[head_q]] = 1'b0;
        if (ld_issue)
            busy_d[ld_addr] = 1'b1;
    end

    always_comb begin
        we_d    = gnt_imm || gnt_alu || gnt_lq;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_imm) begin
            waddr_d = IMM_REG;
            wdata_d = imm_data;
        end else if (gnt_alu) begin
            waddr_d = alu_addr;
            wdata_d = alu_data;
        end else if (gnt_lq) begin
            waddr_d = lq_addr_q[head_q];
            wdata_d = lq_data_q[head_q];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Queue payload needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge Clk) begin
        lq_addr_q <= lq_addr_d;
        lq_data_q <= lq_data_d;
    end

    assign stall    = busy_q[src_a_addr] | busy_q[src_b_addr] | (ld_issue & busy_q[ld_addr]);
    assign busy_vec = busy_q;
    assign WriteEn  = we_q;
    assign Waddr    = waddr_q;
    assign DataIn   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write-port arbitration, load queue, scoreboard and reset.
module tb_regfile_wb_arbiter;
    localparam int W = 8;
    localparam int A = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            imm_valid;
    logic [W-1:0]    imm_data;
    logic            imm_ready;
    logic            alu_valid;
    logic [A-1:0]    alu_addr;
    logic [W-1:0]    alu_data;
    logic            alu_ready;
    logic            ld_issue;
    logic [A-1:0]    ld_addr;
    logic            ld_ret_valid;
    logic [A-1:0]    ld_ret_addr;
    logic [W-1:0]    ld_ret_data;
    logic            ld_ret_ready;
    logic [A-1:0]    src_a_addr;
    logic [A-1:0]    src_b_addr;
    logic            stall;
    logic [2**A-1:0] busy_vec;
    logic            WriteEn;
    logic [A-1:0]    Waddr;
    logic [W-1:0]    DataIn;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_arbiter #(.W(W), .A(A), .LQ_DEPTH(2), .MAX_WAIT(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .imm_valid(imm_valid), .imm_data(imm_data), .imm_ready(imm_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_addr(ld_addr),
        .ld_ret_valid(ld_ret_valid), .ld_ret_addr(ld_ret_addr), .ld_ret_data(ld_ret_data),
        .ld_ret_ready(ld_ret_ready),
        .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .stall(stall), .busy_vec(busy_vec),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [A-1:0] addr, input logic [W-1:0] data);
        check_eq({tag, "_we"},   32'(WriteEn), 1);
        check_eq({tag, "_addr"}, 32'(Waddr),   32'(addr));
        check_eq({tag, "_data"}, 32'(DataIn),  32'(data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        imm_valid = 1'b0; imm_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_issue = 1'b0; ld_addr = '0;
        ld_ret_valid = 1'b0; ld_ret_addr = '0; ld_ret_data = '0;
        src_a_addr = '0; src_b_addr = '0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check_eq("rst_we",       32'(WriteEn),      0);
        check_eq("rst_waddr",    32'(Waddr),        0);
        check_eq("rst_datain",   32'(DataIn),       0);
        check_eq("rst_busy",     32'(busy_vec),     0);
        check_eq("rst_stall",    32'(stall),        0);
        check_eq("rst_ld_ready", 32'(ld_ret_ready), 1);

        // Single load-immediate
        imm_valid = 1'b1; imm_data = 8'h5A;
        #1;
        check_eq("imm_ready", 32'(imm_ready), 1);
        check_eq("imm_alu_ready_idle", 32'(alu_ready), 0);
        tick();
        check_write("imm_wr", 4'd3, 8'h5A);
        imm_valid = 1'b0;
        tick();
        check_eq("imm_we_drop", 32'(WriteEn), 0);
        check_eq("imm_hold_addr", 32'(Waddr), 3);
        check_eq("imm_hold_data", 32'(DataIn), 'h5A);

        // IMM beats ALU, ALU follows next cycle
        imm_valid = 1'b1; imm_data = 8'h22;
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 8'h11;
        #1;
        check_eq("pri_imm_ready", 32'(imm_ready), 1);
        check_eq("pri_alu_wait",  32'(alu_ready), 0);
        tick();
        check_write("pri_imm_wr", 4'd3, 8'h22);
        imm_valid = 1'b0;
        #1;
        check_eq("pri_alu_ready", 32'(alu_ready), 1);
        tick();
        check_write("pri_alu_wr", 4'd4, 8'h11);
        alu_valid = 1'b0;
        tick();
        check_eq("pri_idle_we", 32'(WriteEn), 0);

        // Scoreboard and stall on a load to r5
        ld_issue = 1'b1; ld_addr = 4'd5;
        #1;
        check_eq("sb_issue_nostall", 32'(stall), 0);
        tick();
        ld_issue = 1'b0;
        check_eq("sb_busy5", 32'(busy_vec), 'h0020);
        src_a_addr = 4'd5;
        #1;
        check_eq("sb_stall_a", 32'(stall), 1);
        src_a_addr = 4'd0; src_b_addr = 4'd5;
        #1;
        check_eq("sb_stall_b", 32'(stall), 1);
        src_b_addr = 4'd0;
        #1;
        check_eq("sb_nostall", 32'(stall), 0);
        ld_issue = 1'b1;
        #1;
        check_eq("sb_stall_waw_issue", 32'(stall), 1);
        ld_issue = 1'b0;
        src_a_addr = 4'd5;
        ld_ret_valid = 1'b1; ld_ret_addr = 4'd5; ld_ret_data = 8'h77;
        #1;
        check_eq("ld_ready_empty", 32'(ld_ret_ready), 1);
        tick();
        ld_ret_valid = 1'b0;
        check_eq("ld_no_write_yet", 32'(WriteEn), 0);
        check_eq("ld_stall_held",   32'(stall), 1);
        tick();
        check_write("ld_wr", 4'd5, 8'h77);
        check_eq("ld_busy_clear", 32'(busy_vec), 0);
        check_eq("ld_stall_clear", 32'(stall), 0);
        src_a_addr = 4'd0;
        tick();
        check_eq("ld_idle_we", 32'(WriteEn), 0);

        // IMM and ALU blocked by an outstanding load to r3
        ld_issue = 1'b1; ld_addr = 4'd3;
        tick();
        ld_issue = 1'b0;
        imm_valid = 1'b1; imm_data = 8'h33;
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 8'h44;
        #1;
        check_eq("r3_imm_blocked", 32'(imm_ready), 0);
        check_eq("r3_alu_waw",     32'(alu_ready), 0);
        alu_valid = 1'b0;
        ld_ret_valid = 1'b1; ld_ret_addr = 4'd3; ld_ret_data = 8'h99;
        tick();
        ld_ret_valid = 1'b0;
        check_eq("r3_no_write", 32'(WriteEn), 0);
        tick();
        check_write("r3_ld_wr", 4'd3, 8'h99);
        check_eq("r3_busy_clear", 32'(busy_vec), 0);
        #1;
        check_eq("r3_imm_ready", 32'(imm_ready), 1);
        tick();
        check_write("r3_imm_wr", 4'd3, 8'h33);
        imm_valid = 1'b0;
        tick();

        // LQ fill with ALU traffic, back-pressure and FIFO drain
        ld_issue = 1'b1; ld_addr = 4'd8;  tick();
        ld_addr = 4'd9;  tick();
        ld_addr = 4'd10; tick();
        ld_issue = 1'b0;
        check_eq("fill_busy", 32'(busy_vec), 'h0700);
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 8'hA0;
        ld_ret_valid = 1'b1; ld_ret_addr = 4'd8; ld_ret_data = 8'h81;
        #1;
        check_eq("fill_rdy1", 32'(ld_ret_ready), 1);
        check_eq("fill_alu1", 32'(alu_ready), 1);
        tick();
        check_write("fill_alu_wr", 4'd7, 8'hA0);
        ld_ret_addr = 4'd9; ld_ret_data = 8'h92;
        #1;
        check_eq("fill_rdy2", 32'(ld_ret_ready), 1);
        check_eq("fill_alu2", 32'(alu_ready), 1);
        tick();
        ld_ret_addr = 4'd10; ld_ret_data = 8'hA3;
        #1;
        check_eq("fill_full", 32'(ld_ret_ready), 0);
        check_eq("fill_alu3", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        #1;
        check_eq("fill_still_full", 32'(ld_ret_ready), 0);
        tick();
        check_write("drain_r8", 4'd8, 8'h81);
        check_eq("drain_busy1", 32'(busy_vec), 'h0600);
        #1;
        check_eq("drain_rdy", 32'(ld_ret_ready), 1);
        tick();
        ld_ret_valid = 1'b0;
        check_write("drain_r9", 4'd9, 8'h92);
        check_eq("drain_busy2", 32'(busy_vec), 'h0400);
        tick();
        check_write("drain_r10", 4'd10, 8'hA3);
        check_eq("drain_busy3", 32'(busy_vec), 0);
        tick();
        check_eq("drain_idle", 32'(WriteEn), 0);

        // LQ head against continuous ALU traffic
        ld_issue = 1'b1; ld_addr = 4'd11;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd11; alu_data = 8'hB0;
        #1;
        check_eq("age_alu_waw", 32'(alu_ready), 0);
        alu_addr = 4'd7; alu_data = 8'hC0;
        ld_ret_valid = 1'b1; ld_ret_addr = 4'd11; ld_ret_data = 8'hBB;
        #1;
        check_eq("age_alu_ok", 32'(alu_ready), 1);
        tick();
        ld_ret_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic           exp_alu;
            logic [A-1:0]   exp_addr;
            logic [W-1:0]   exp_data;
`ifdef REGFILE_WB_AGING_EN
            exp_alu  = (k != 4);
            exp_addr = (k == 4) ? 4'd11 : 4'd7;
            exp_data = (k == 4) ? 8'hBB : 8'hC0;
`else
            exp_alu  = 1'b1;
            exp_addr = 4'd7;
            exp_data = 8'hC0;
`endif
            #1;
            check_eq($sformatf("age_k%0d_alu_ready", k), 32'(alu_ready), 32'(exp_alu));
            tick();
            check_write($sformatf("age_k%0d", k), exp_addr, exp_data);
        end
        alu_valid = 1'b0;
        tick();
`ifdef REGFILE_WB_AGING_EN
        check_eq("age_after_idle", 32'(WriteEn), 0);
`else
        check_write("starve_release", 4'd11, 8'hBB);
`endif
        check_eq("age_busy_clear", 32'(busy_vec), 0);
        tick();

        // Reset with a full LQ and outstanding loads
        ld_issue = 1'b1; ld_addr = 4'd5; tick();
        ld_addr = 4'd6; tick();
        ld_issue = 1'b0;
        check_eq("mrst_busy_pre", 32'(busy_vec), 'h0060);
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 8'hC1;
        ld_ret_valid = 1'b1; ld_ret_addr = 4'd5; ld_ret_data = 8'h55;
        tick();
        ld_ret_addr = 4'd6; ld_ret_data = 8'h66;
        tick();
        ld_ret_valid = 1'b0;
        #1;
        check_eq("mrst_lq_full", 32'(ld_ret_ready), 0);
        Reset = 1'b1;
        alu_valid = 1'b0;
        tick();
        check_eq("mrst_we",     32'(WriteEn),  0);
        check_eq("mrst_waddr",  32'(Waddr),    0);
        check_eq("mrst_datain", 32'(DataIn),   0);
        check_eq("mrst_busy",   32'(busy_vec), 0);
        Reset = 1'b0;
        #1;
        check_eq("mrst_ld_ready", 32'(ld_ret_ready), 1);
        check_eq("mrst_stall",    32'(stall), 0);
        tick();
        check_eq("mrst_no_wr1", 32'(WriteEn), 0);
        tick();
        check_eq("mrst_no_wr2", 32'(WriteEn), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
